mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 256x32 main memory between the IF stage (read-only) and the MEM stage (load/store).
//  Grants one requester per transaction and holds memory strobes for MEM_LAT cycles.
//  Returns read data with a one-cycle ready pulse; requesters stall on req && !ready.
//  Sits between the pipeline stage registers and the memory array.
// PARAMETERS
//  DATA_W   32   data width of all data buses
//  ADDR_W   8    word-index bits used; 256 words
//  MEM_LAT  2    cycles strobes are held per access (1..15)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  if_req     in   1       instruction fetch request; held until if_ready
//  if_addr    in   32      fetch word address
//  if_rdata   out  DATA_W  fetched word; valid when if_ready
//  if_ready   out  1       one-cycle completion pulse for IF
//  dm_req     in   1       data request; held until dm_ready
//  dm_we      in   1       1 = store, 0 = load; held with dm_req
//  dm_addr    in   32      data word address
//  dm_wdata   in   DATA_W  store data
//  dm_rdata   out  DATA_W  load data; valid when dm_ready
//  dm_ready   out  1       one-cycle completion pulse for MEM
//  m_addr     out  32      memory address
//  m_wdata    out  DATA_W  memory write data
//  m_read     out  1       MemRead strobe
//  m_write    out  1       MemWrite strobe
//  m_rdata    in   DATA_W  memory read data
//  oob_err    out  1       sticky: an access had dm_addr/if_addr bits above ADDR_W set
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; grant register = IF; latency count 0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: when any req is high, choose the winner, latch addr/we/wdata, and go to ACCESS next cycle.
//  ACCESS: drive m_addr/m_wdata and m_read (load/fetch) or m_write (store) for exactly MEM_LAT cycles.
//    Count from MEM_LAT-1 down to 0. On count 0, register m_rdata into the winner's rdata and go to RESP.
//  RESP: pulse the winner's ready for 1 cycle; strobes are 0; go to IDLE.
//  Latency: req high in IDLE at cycle t gives ready at t+MEM_LAT+1.
//  Gap: at least 1 IDLE cycle between transactions.
//  Stores: dm_rdata is left unchanged; dm_ready still pulses.
//  Requester rule: req and its inputs stay stable until ready. Requests are not re-sampled mid-transaction.
//  A req still high in the cycle after ready is a new request.
//  Priority, default: dm wins over if (older instruction first).
//  Out of range (addr[31:ADDR_W] != 0):
//    Write strobe is suppressed; the read returns 0.
//    Ready still pulses; oob_err sets and stays set until reset.
//  Reset mid-transaction: abort; strobes drop in the same cycle reset is sampled; no ready pulse is issued.
//  Non-granted rdata/ready: both 0 at all times except the winner's registered data.
// CONFIGURATION
//  MEM_ARB_RR_EN defined:
//    When both requests are pending in IDLE, grant the requester not served last.
//    A 1-bit last_grant register updates on each grant; its reset value is IF, so dm wins the first tie.
//    A lone requester is always granted.
//  MEM_ARB_RR_EN undefined: fixed dm-over-if priority; no last_grant register.
// STRUCTURE
//  Package mem_arb_pkg:
//    state encoding (IDLE/ACCESS/RESP)
//    grant encoding (GNT_IF/GNT_DM)
//    LAT_CNT_W = 4 constant
//  Sub-module mem_arb_lat_cnt: loadable down-counter (load MEM_LAT-1, dec, zero flag).
//  Everything else is inline.
// TESTING
//  1. Lone load: dm_req=1, dm_we=0, dm_addr=5 with mem[5]=0xCAFEF00D, MEM_LAT=2
//     -> m_read high 2 cycles; dm_ready at t+3 with dm_rdata=0xCAFEF00D.
//  2. Store then fetch: dm store 0x12345678 @7, then if_req @7
//     -> m_write high 2 cycles; then if_rdata=0x12345678 on if_ready.
//  3. Simultaneous reqs, fixed priority, both held for 3 transactions
//     -> order dm, dm, dm; if starves while dm_req is held.
//     With MEM_ARB_RR_EN -> order dm, if, dm.
//  4. dm_addr=0x100 store -> no m_write; dm_ready pulses; oob_err=1 and stays 1.
//     Load @0x100 -> dm_rdata=0.
//  5. Reset asserted in the 2nd ACCESS cycle
//     -> next cycle m_read=0, no ready, state IDLE, all outputs 0, oob_err cleared.
//  6. MEM_LAT=1 back-to-back if fetches @0,1,2 -> ready every 3rd cycle, data in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Optional build macro in the arbiter: MEM_ARB_RR_EN (round-robin tie break).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } arb_gnt_t;

  localparam int unsigned LAT_CNT_W = 4;

  // True when any address bit at or above the used word-index width is set.
  function automatic logic addr_above(input logic [31:0] a, input int unsigned aw);
    return (a >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter timing how long the memory strobes are held.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [LAT_CNT_W-1:0] r_cnt;

  // Load MEM_LAT-1 at grant, then count down to 0 and hold there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LAT_CNT_W'(MEM_LAT - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between instruction fetch (IF)
// and the data stage (DM). One transaction at a time: IDLE -> ACCESS -> RESP.
// Optional build macro: MEM_ARB_RR_EN -- on a tie, grant the requester not
// served last (dm wins the first tie); otherwise dm always beats if.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic [31:0]       m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              oob_err
);

  arb_state_t        r_state;
  arb_gnt_t          r_gnt;
  logic              r_we;
  logic              r_oob;
  logic [31:0]       r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_m_read;
  logic              r_m_write;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ready;
  logic              r_dm_ready;
  logic              r_oob_err;

  arb_gnt_t          w_gnt;
  logic              w_any_req;
  logic [31:0]       w_sel_addr;
  logic              w_sel_we;
  logic              w_sel_oob;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

`ifdef MEM_ARB_RR_EN
  arb_gnt_t          r_last_gnt;
`endif

  assign w_any_req = if_req | dm_req;

  // Winner selection for the IDLE grant decision.
  always_comb begin
    w_gnt = GNT_IF;
`ifdef MEM_ARB_RR_EN
    if (dm_req && if_req) begin
      w_gnt = (r_last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
    end else if (dm_req) begin
      w_gnt = GNT_DM;
    end
`else
    if (dm_req) begin
      w_gnt = GNT_DM;
    end
`endif
  end

  assign w_sel_addr = (w_gnt == GNT_DM) ? dm_addr : if_addr;
  assign w_sel_we   = (w_gnt == GNT_DM) & dm_we;
  assign w_sel_oob  = addr_above(w_sel_addr, ADDR_W);
  assign w_rd_data  = r_oob ? '0 : m_rdata;

  assign w_cnt_load = (r_state == ST_IDLE) & w_any_req;
  assign w_cnt_dec  = (r_state == ST_ACCESS) & ~w_cnt_zero;

  mem_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

`ifdef MEM_ARB_RR_EN
  // Remember who was granted last, for the tie break.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= GNT_IF;
    end else if (w_cnt_load) begin
      r_last_gnt <= w_gnt;
    end
  end
`endif

  // Transaction FSM with registered strobes, data and ready pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= GNT_IF;
      r_we       <= 1'b0;
      r_oob      <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_read   <= 1'b0;
      r_m_write  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_oob_err  <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt     <= w_gnt;
            r_we      <= w_sel_we;
            r_oob     <= w_sel_oob;
            r_m_addr  <= w_sel_addr;
            r_m_wdata <= (w_gnt == GNT_DM) ? dm_wdata : '0;
            r_m_read  <= ~w_sel_we;
            r_m_write <= w_sel_we & ~w_sel_oob;
            if (w_sel_oob) begin
              r_oob_err <= 1'b1;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_cnt_zero) begin
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            // Only the winner keeps data; the other port reads back 0.
            if (r_gnt == GNT_DM) begin
              r_dm_ready <= 1'b1;
              r_if_rdata <= '0;
              if (!r_we) begin
                r_dm_rdata <= w_rd_data;
              end
            end else begin
              r_if_ready <= 1'b1;
              r_if_rdata <= w_rd_data;
              r_dm_rdata <= '0;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rdata = r_if_rdata;
  assign if_ready = r_if_ready;
  assign dm_rdata = r_dm_rdata;
  assign dm_ready = r_dm_ready;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_read   = r_m_read;
  assign m_write  = r_m_write;
  assign oob_err  = r_oob_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance,
// MEM_LAT=1 second instance for back-to-back fetches).
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned LAT1 = 1;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, m_addr, m_wdata, m_rdata;
  logic        if_ready, dm_ready, m_read, m_write, oob_err;

  logic        if1_req;
  logic [31:0] if1_addr;
  logic [31:0] if1_rdata, dm1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        if1_ready, dm1_ready, m1_read, m1_write, oob1_err;

  logic [31:0] mem  [256];
  logic [31:0] mem1 [256];

  assign m_rdata  = mem[m_addr[7:0]];
  assign m1_rdata = mem1[m1_addr[7:0]];

  // Memory models: preload on reset, write on the MemWrite strobe.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= 32'h0;
        mem1[i] <= 32'h0;
      end
      mem[0]    <= 32'hDEAD0000;
      mem[5]    <= 32'hCAFEF00D;
      mem[9]    <= 32'h0BADBEEF;
      mem[255]  <= 32'hFFFF0001;
      mem1[0]   <= 32'h11111111;
      mem1[1]   <= 32'h22222222;
      mem1[2]   <= 32'h33333333;
    end else begin
      if (m_write)  mem[m_addr[7:0]]   <= m_wdata;
      if (m1_write) mem1[m1_addr[7:0]] <= m1_wdata;
    end
  end

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .oob_err(oob_err)
  );

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_ready(if1_ready),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_rdata(dm1_rdata), .dm_ready(dm1_ready),
    .m_addr(m1_addr), .m_wdata(m1_wdata), .m_read(m1_read), .m_write(m1_write),
    .m_rdata(m1_rdata), .oob_err(oob1_err)
  );

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int unsigned lat;
    logic        oob;
  } exp_t;

  vec_t        vecs [9];
  exp_t        sb_q [$];
  int unsigned n_err    = 0;
  int unsigned n_checks = 0;
  logic        oob_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int unsigned edges = 0, n_rd = 0, n_wr = 0;
    logic got = 1'b0, other_rdy = 1'b0, bad_bus = 1'b0, acc_oob;
    exp_t e;
    acc_oob = (v.addr >> 8) != 32'd0;
    @(negedge clk);
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    oob_model = oob_model | acc_oob;
    e.rdata = v.exp_rdata; e.lat = LAT + 1; e.oob = oob_model;
    sb_q.push_back(e);
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (m_read)  n_rd++;
      if (m_write) n_wr++;
      if ((m_read || m_write) && (m_addr !== v.addr)) bad_bus = 1'b1;
      if (m_write && (m_wdata !== v.wdata)) bad_bus = 1'b1;
      if (v.dm ? dm_ready : if_ready) got = 1'b1;
      if (v.dm ? if_ready : dm_ready) other_rdy = 1'b1;
    end
    dm_req = 1'b0; if_req = 1'b0; dm_we = 1'b0;
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", tag);
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_latency"}, edges, e.lat);
    check({tag, "_rdata"}, v.dm ? dm_rdata : if_rdata, e.rdata);
    check({tag, "_other_rdata"}, v.dm ? if_rdata : dm_rdata, 32'h0);
    check({tag, "_other_ready"}, {31'b0, other_rdy}, 32'h0);
    check({tag, "_bus"}, {31'b0, bad_bus}, 32'h0);
    check({tag, "_wr_cycles"}, n_wr, (v.we && !acc_oob) ? LAT : 0);
    if (!acc_oob) check({tag, "_rd_cycles"}, n_rd, v.we ? 0 : LAT);
    check({tag, "_oob_err"}, {31'b0, oob_err}, {31'b0, e.oob});
    @(posedge clk); #1;
    check({tag, "_ready_pulse"}, {30'b0, dm_ready, if_ready}, 32'h0);
  endtask

  initial begin
    int unsigned order [3];
    int unsigned exp_order [3];
    int unsigned nrdy;
    int unsigned edges;
    int unsigned last_edge;
    logic        seen;
    logic [31:0] exp_d;

    // dm, we, addr, wdata, expected rdata on the requester's port
    vecs[0] = '{1'b1, 1'b0, 32'd5,        32'h0,        32'hCAFEF00D};
    vecs[1] = '{1'b1, 1'b1, 32'd7,        32'h12345678, 32'hCAFEF00D};
    vecs[2] = '{1'b0, 1'b0, 32'd7,        32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 32'd255,      32'h0,        32'hFFFF0001};
    vecs[4] = '{1'b1, 1'b0, 32'd9,        32'h0,        32'h0BADBEEF};
    vecs[5] = '{1'b1, 1'b1, 32'h100,      32'hAAAA5555, 32'h0BADBEEF};
    vecs[6] = '{1'b1, 1'b0, 32'h100,      32'h0,        32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h80000000, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'd0,        32'h0,        32'hDEAD0000};

`ifdef MEM_ARB_RR_EN
    exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1;
`else
    exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 1;
`endif

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if1_req = 1'b0; if1_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("reset_outputs",
          {if_rdata ^ dm_rdata ^ m_addr ^ m_wdata, 27'b0, if_ready, dm_ready, m_read, m_write, oob_err} == 64'h0 ? 32'h0 : 32'h1,
          32'h0);
    check("reset_rdata_or", if_rdata | dm_rdata | m_addr | m_wdata, 32'h0);

    // Table-driven single transactions (loads, stores, out-of-range)
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Both requesters held for three transactions
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd5;
    if_req = 1'b1; if_addr = 32'd9;
    nrdy = 0; edges = 0;
    while (nrdy < 3 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (dm_ready || if_ready) begin
        order[nrdy] = dm_ready ? 1 : 0;
        exp_d = dm_ready ? 32'hCAFEF00D : 32'h0BADBEEF;
        check($sformatf("tie%0d_rdata", nrdy), dm_ready ? dm_rdata : if_rdata, exp_d);
        nrdy++;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    if (nrdy < 3) begin
      n_checks++; n_err++;
      $display("FAIL tie_timeout: got %0d readies expected 3", nrdy);
    end else begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("tie%0d_order", k), order[k], exp_order[k]);
      end
    end
    repeat (2) @(posedge clk);

    // Reset during the second ACCESS cycle of a load
    check("pre_reset_oob_err", {31'b0, oob_err}, 32'h1);
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_access", {31'b0, m_read}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    dm_req = 1'b0;
    check("abort_strobes", {30'b0, m_read, m_write}, 32'h0);
    check("abort_ready", {30'b0, if_ready, dm_ready}, 32'h0);
    check("abort_oob_err", {31'b0, oob_err}, 32'h0);
    check("abort_buses", if_rdata | dm_rdata | m_addr | m_wdata, 32'h0);
    @(negedge clk); reset = 1'b0;
    oob_model = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (if_ready || dm_ready || m_read || m_write) seen = 1'b1;
    end
    check("abort_quiet", {31'b0, seen}, 32'h0);
    run_txn(vecs[0], "post_reset");

    // MEM_LAT=1: back-to-back fetches @0,1,2 on the second instance
    @(negedge clk);
    if1_req = 1'b1; if1_addr = 32'd0;
    sb_q.push_back('{32'h11111111, LAT1 + 1, 1'b0});
    nrdy = 0; edges = 0; last_edge = 0;
    while (nrdy < 3 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (if1_ready) begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("b2b%0d_rdata", nrdy), if1_rdata, e.rdata);
        check($sformatf("b2b%0d_spacing", nrdy), edges - last_edge, (nrdy == 0) ? e.lat : 3);
        last_edge = edges;
        nrdy++;
        if (nrdy < 3) begin
          if1_addr = nrdy;
          sb_q.push_back('{(nrdy == 1) ? 32'h22222222 : 32'h33333333, 3, 1'b0});
        end else begin
          if1_req = 1'b0;
        end
      end
    end
    if1_req = 1'b0;
    if (nrdy < 3) begin
      n_checks++; n_err++;
      $display("FAIL b2b_timeout: got %0d readies expected 3", nrdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
